// File: rtl/kbd_matrix_map.sv
// PS/2 scancode to keyboard-matrix translator: a loadable map picks the matrix position,
// a pressed-key bitmap drives active-low row sense, and reset/NMI requests are stretched.
module kbd_matrix_map #(
   parameter int unsigned NCOLS    = 8,
   parameter int unsigned NROWS    = 8,
   parameter int unsigned RST_MIN  = 65536,
   parameter int unsigned NMI_MIN  = 1024,
   parameter string       MAP_INIT = "",
   localparam int unsigned CW      = $clog2(NCOLS),
   localparam int unsigned RW      = $clog2(NROWS),
   localparam int unsigned MW      = 3 + CW + RW
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             clk_en,
   input  logic             key_strobe,
   input  logic             key_pressed,
   input  logic             key_extended,
   input  logic [7:0]       key_code,
   input  logic [CW-1:0]    col,
   output logic [NROWS-1:0] row_out,
   input  logic             release_all,
   input  logic             map_we,
   input  logic [8:0]       map_addr,
   input  logic [MW-1:0]    map_data,
   output logic             any_key,
   output logic [7:0]       key_count,
   output logic             swrst,
   output logic             swnmi
);

   localparam int unsigned RCW = $clog2(RST_MIN + 1);
   localparam int unsigned NCW = $clog2(NMI_MIN + 1);

   typedef enum logic [1:0] {
      KindMatrix = 2'b00,
      KindReset  = 2'b01,
      KindNmi    = 2'b10,
      KindIgnore = 2'b11
   } kind_e;

   logic                        s0_valid_q, s0_pressed_q;
   logic [8:0]                  s0_addr_q;
   logic                        s1_valid_q, s1_pressed_q;
   logic [MW-1:0]               s1_entry_q;
   logic [MW-1:0]               map_mem [512];

   logic [NCOLS-1:0][NROWS-1:0] bitmap_q, bitmap_d;
   logic [7:0]                  key_count_q, key_count_d;
   logic                        rst_held_q, rst_held_d, rst_prev_q;
   logic                        nmi_held_q, nmi_held_d, nmi_prev_q;
   logic [RCW-1:0]              rst_cnt_q, rst_cnt_d;
   logic [NCW-1:0]              nmi_cnt_q, nmi_cnt_d;

   logic                        ent_valid, ent_ok;
   kind_e                       ent_kind;
   logic [CW-1:0]               ent_col;
   logic [RW-1:0]               ent_row;

   // S0 capture and S1 valid tracking
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         s0_valid_q   <= 1'b0;
         s0_pressed_q <= 1'b0;
         s0_addr_q    <= '0;
         s1_valid_q   <= 1'b0;
         s1_pressed_q <= 1'b0;
      end else begin
         s0_valid_q   <= key_strobe;
         if (key_strobe) begin
            s0_pressed_q <= key_pressed;
            s0_addr_q    <= {key_extended, key_code};
         end
         s1_valid_q   <= s0_valid_q;
         s1_pressed_q <= s0_pressed_q;
      end
   end

   // Map RAM is never reset; a same-address write and read returns the old entry
   always_ff @(posedge clk_sys) begin
      if (map_we) begin
         map_mem[map_addr] <= map_data;
      end
      s1_entry_q <= map_mem[s0_addr_q];
   end

   assign ent_valid = s1_entry_q[MW-1];
   assign ent_kind  = kind_e'(s1_entry_q[MW-2 -: 2]);
   assign ent_col   = s1_entry_q[RW +: CW];
   assign ent_row   = s1_entry_q[RW-1:0];
   assign ent_ok    = s1_valid_q && ent_valid &&
                      (32'(ent_col) < NCOLS) && (32'(ent_row) < NROWS);

   always_comb begin
      bitmap_d    = bitmap_q;
      key_count_d = key_count_q;
      rst_held_d  = rst_held_q;
      nmi_held_d  = nmi_held_q;
      if (release_all) begin
         bitmap_d    = '0;
         key_count_d = '0;
         rst_held_d  = 1'b0;
         nmi_held_d  = 1'b0;
      end else if (ent_ok) begin
         case (ent_kind)
            KindMatrix: begin
               // Count only real bit transitions so typematic repeats are invisible
               if (s1_pressed_q && !bitmap_q[ent_col][ent_row]) begin
                  bitmap_d[ent_col][ent_row] = 1'b1;
                  if (key_count_q != 8'hFF) key_count_d = key_count_q + 8'd1;
               end else if (!s1_pressed_q && bitmap_q[ent_col][ent_row]) begin
                  bitmap_d[ent_col][ent_row] = 1'b0;
                  if (key_count_q != 8'h00) key_count_d = key_count_q - 8'd1;
               end
            end
            KindReset:  rst_held_d = s1_pressed_q;
            KindNmi:    nmi_held_d = s1_pressed_q;
            KindIgnore: ;
            default:    ;
         endcase
      end
   end

   // Counters load on the cycle after the held flop rises, so a one-cycle hold
   // still yields exactly RST_MIN / NMI_MIN cycles of output
   always_comb begin
      rst_cnt_d = rst_cnt_q;
      if (rst_held_q && !rst_prev_q) begin
         rst_cnt_d = RCW'(RST_MIN - 1);
      end else if (rst_cnt_q != '0) begin
         rst_cnt_d = rst_cnt_q - RCW'(1);
      end
      nmi_cnt_d = nmi_cnt_q;
      if (nmi_held_q && !nmi_prev_q) begin
         nmi_cnt_d = NCW'(NMI_MIN - 1);
      end else if (nmi_cnt_q != '0) begin
         nmi_cnt_d = nmi_cnt_q - NCW'(1);
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         bitmap_q    <= '0;
         key_count_q <= '0;
         rst_held_q  <= 1'b0;
         rst_prev_q  <= 1'b0;
         nmi_held_q  <= 1'b0;
         nmi_prev_q  <= 1'b0;
         rst_cnt_q   <= '0;
         nmi_cnt_q   <= '0;
         row_out     <= '1;
      end else begin
         bitmap_q    <= bitmap_d;
         key_count_q <= key_count_d;
         rst_held_q  <= rst_held_d;
         rst_prev_q  <= rst_held_q;
         nmi_held_q  <= nmi_held_d;
         nmi_prev_q  <= nmi_held_q;
         rst_cnt_q   <= rst_cnt_d;
         nmi_cnt_q   <= nmi_cnt_d;
         if (clk_en) begin
            row_out <= (32'(col) < NCOLS) ? ~bitmap_q[col] : '1;
         end
      end
   end

   assign any_key   = |bitmap_q;
   assign key_count = key_count_q;
   assign swrst     = rst_held_q | (rst_cnt_q != '0);
   assign swnmi     = nmi_held_q | (nmi_cnt_q != '0);

endmodule
